sys_bus_arbiter: RTL
====================

Name: sys_bus_arbiter

Overview:
- Arbitrates one synchronous single-port RAM among NUM_PORTS requesters: video fetch, CPU, and future DMA/audio masters.
- Replaces the ad-hoc "video read overrides CPU address" mux with a handshake, so no access is silently lost.
- Also generates the CPU clock-enable strobe. The CPU runs on the system clock, gated by ce and stalled via RDY until its access is granted.

Parameters:
- NUM_PORTS, 3, number of requesters (2..8).
- ADDR_WIDTH, 11, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- PRIO0, 1, 1 = port 0 has fixed highest priority and ports 1..N-1 are round-robin; 0 = all ports round-robin.
- CE_DIV, 2048, clock-enable period in clk cycles (1..65535).

Ports:
- clk  in  1  system clock (25 MHz domain); single clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_PORTS  per-port access request.
- we  in  NUM_PORTS  per-port write flag, qualified by req.
- addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port i at [i*AW +: AW].
- wdata  in  NUM_PORTS*DATA_WIDTH  packed write data; port i at [i*DW +: DW].
- gnt  out  NUM_PORTS  one-hot, one-cycle pulse: access issued.
- rvalid  out  NUM_PORTS  one-hot, one-cycle pulse: rdata valid for port i.
- rdata  out  DATA_WIDTH  read data, shared by all ports.
- mem_addr  out  ADDR_WIDTH  registered RAM address.
- mem_we  out  1  registered RAM write enable.
- mem_wdata  out  DATA_WIDTH  registered RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM output, valid 1 cycle after mem_addr.
- ce  out  1  clock-enable pulse, one cycle every CE_DIV clks.

Behaviour:
- Reset values (asynchronous): gnt=0, rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, ce=0, ce counter=0, RR pointer=0 (next RR search starts at the lowest RR port).

Requester protocol:
- Hold req, we, addr and wdata stable from assertion until gnt[i] is seen high at a rising edge.
- Req may then be dropped, or kept high for another access.
- In any cycle where gnt[i]=1, port i is masked from arbitration. Consequence: a single port is granted at most every 2nd cycle, and a requester's stale req is never double-granted.

Arbitration (every cycle):
- Eligible = req & ~gnt.
- If PRIO0=1 and port 0 is eligible, port 0 wins.
- Otherwise, among the RR ports, the first eligible port after the RR pointer wins, searching with wrap-around.
- The RR pointer updates to the winner only when the winner is an RR port. A port-0 grant leaves the pointer unchanged.
- No eligible port: no grant, and mem_we=0.

Grant cycle:
- At the edge following arbitration, the block registers mem_addr, mem_we (=we[win]) and mem_wdata from the winner, and asserts gnt[win] for exactly one cycle.
- Latency: req asserted in cycle 0 with the bus idle gives gnt in cycle 1, RAM access in cycle 1, and rvalid in cycle 2.

Read return:
- For a read grant in cycle n, rvalid[win]=1 in cycle n+1.
- rdata is combinationally driven from mem_rdata; it is don't-care when no rvalid is high.
- Writes never produce rvalid.

Pipelining:
- Grants may be issued on consecutive cycles to different ports.
- rvalid for grant n may coincide with gnt for grant n+1.
- mem_we drops to 0 in any cycle without a write grant.
- mem_addr holds its last value when idle.

Simultaneous events:
- Several new requests plus a pending one are resolved by the priority rules above.
- A request from the currently granted port is ignored for that cycle.

Reset mid-operation:
- Outstanding grants and rvalids are dropped; no pulse is emitted after reset.
- Requesters must re-issue their requests.

Clock enable:
- A counter runs 0..CE_DIV-1. ce=1 in the cycle when the counter equals CE_DIV-1, and the counter then wraps to 0.
- CE_DIV=1 gives ce constantly 1 after the first clock following reset release.

Widths:
- Counter width is clog2(CE_DIV)+1.
- RR pointer width is clog2(NUM_PORTS).
- All indices wrap modulo NUM_PORTS.

Test Plan:
- Single read: NUM_PORTS=3. Preload RAM[0x123]=0xA5; port 1 reads 0x123 → gnt=3'b010 after 1 cycle, mem_we=0, rvalid=3'b010 the next cycle, rdata=0xA5.
- Write then read: port 2 writes 0x5A to 0x7FF, then reads 0x7FF → mem_we=1 only in its grant cycle, no rvalid for the write, the read returns 0x5A.
- Priority: PRIO0=1, req=3'b111 held continuously → grant order 0,1,0,2,0,1… Port 0 is masked on alternate cycles and never starves. With PRIO0=0 the order is 0,1,2,0,1,2.
- RR fairness: ports 1 and 2 held requesting for 100 cycles, with port 0 idle → grant counts differ by ≤1 and there are no consecutive grants to the same port.
- ce: CE_DIV=4 → ce pulses at cycles 3, 7, 11 after reset release. CE_DIV=1 → ce is constantly 1.
- Reset mid-access: assert reset during the gnt cycle of a read → gnt, rvalid and mem_we are 0 immediately. After release, no rvalid appears and the RR pointer is restarted.

Source files
------------

// File: rtl/sys_bus_arbiter.sv
// Single-port RAM arbiter: one grant per cycle with a fixed-priority port 0 and a round-robin
// group, one-cycle read return, and a free-running clock-enable strobe for the CPU.
module sys_bus_arbiter #(
   parameter int NUM_PORTS  = 3,
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 8,
   parameter int PRIO0      = 1,
   parameter int CE_DIV     = 2048
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS-1:0]            req,
   input  logic [NUM_PORTS-1:0]            we,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
   output logic [NUM_PORTS-1:0]            gnt,
   output logic [NUM_PORTS-1:0]            rvalid,
   output logic [DATA_WIDTH-1:0]           rdata,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic                            mem_we,
   output logic [DATA_WIDTH-1:0]           mem_wdata,
   input  logic [DATA_WIDTH-1:0]           mem_rdata,
   output logic                            ce
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam int CW = $clog2(CE_DIV) + 1;
   localparam logic [CW-1:0] CE_LAST = CW'(CE_DIV - 1);
   localparam logic [NUM_PORTS-1:0] RR_MASK = (PRIO0 != 0) ?
      {{(NUM_PORTS-1){1'b1}}, 1'b0} : {NUM_PORTS{1'b1}};

   logic [NUM_PORTS-1:0]  elig_s;
   logic [NUM_PORTS-1:0]  gnt_next_s;
   logic [PW-1:0]         cand_s [NUM_PORTS];
   logic [PW-1:0]         ptr_r;
   logic [PW-1:0]         ptr_next_s;
   logic [PW-1:0]         win_idx_s;
   logic                  win_valid_s;
   logic                  win_rr_s;
   logic                  hit_s;
   logic [NUM_PORTS-1:0]  gnt_r;
   logic [NUM_PORTS-1:0]  rvalid_r;
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic                  mem_we_r;
   logic [DATA_WIDTH-1:0] mem_wdata_r;
   logic [CW-1:0]         ce_cnt_r;
   logic [CW-1:0]         ce_cnt_next_s;
   logic                  ce_r;

   // A port is masked in the cycle it holds a grant, so a stale request is never granted twice
   assign elig_s = req & ~gnt_r;

   // ptr_r is the first index the round-robin search looks at; candidates wrap modulo NUM_PORTS
   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_cand
      logic [PW:0] sum_s;
      assign sum_s     = {1'b0, ptr_r} + (PW+1)'(k);
      assign cand_s[k] = (sum_s >= (PW+1)'(NUM_PORTS)) ?
                         PW'(sum_s - (PW+1)'(NUM_PORTS)) : sum_s[PW-1:0];
   end

   // Winner selection: port 0 first when prioritised, otherwise first eligible round-robin port
   always_comb begin
      win_valid_s = 1'b0;
      win_idx_s   = '0;
      win_rr_s    = 1'b0;
      hit_s       = 1'b0;
      if ((PRIO0 != 0) && elig_s[0]) begin
         win_valid_s = 1'b1;
         win_idx_s   = '0;
      end else begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            hit_s       = !win_valid_s && elig_s[cand_s[k]] && RR_MASK[cand_s[k]];
            win_idx_s   = hit_s ? cand_s[k] : win_idx_s;
            win_valid_s = win_valid_s | hit_s;
         end
         win_rr_s = win_valid_s;
      end
   end

   assign ptr_next_s = (win_idx_s == PW'(NUM_PORTS - 1)) ? '0 : win_idx_s + PW'(1);
   assign gnt_next_s = win_valid_s ? (NUM_PORTS'(1) << win_idx_s) : '0;

   // Grant register, RAM request register and the one-cycle-late read-valid pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_r       <= '0;
         rvalid_r    <= '0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         ptr_r       <= '0;
      end else begin
         gnt_r    <= gnt_next_s;
         rvalid_r <= mem_we_r ? '0 : gnt_r;
         mem_we_r <= win_valid_s & we[win_idx_s];
         if (win_valid_s) begin
            mem_addr_r  <= addr[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_r <= wdata[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
         end
         if (win_rr_s) begin
            ptr_r <= ptr_next_s;
         end
      end
   end

   assign ce_cnt_next_s = (ce_cnt_r == CE_LAST) ? '0 : ce_cnt_r + CW'(1);

   // ce is registered from the next count so it is high exactly while the counter sits at CE_DIV-1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ce_cnt_r <= '0;
         ce_r     <= 1'b0;
      end else begin
         ce_cnt_r <= ce_cnt_next_s;
         ce_r     <= (ce_cnt_next_s == CE_LAST);
      end
   end

   assign gnt       = gnt_r;
   assign rvalid    = rvalid_r;
   assign rdata     = mem_rdata;
   assign mem_addr  = mem_addr_r;
   assign mem_we    = mem_we_r;
   assign mem_wdata = mem_wdata_r;
   assign ce        = ce_r;

endmodule
